pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline controller for the MIPS core. Turns per-stage stall requests into the 6-bit `pause` vector consumed by `pc_reg` and the stage registers. Arbitrates branch and exception redirects into the registered `pc_flush`/`pc_jump` and `pc_exception_flush`/`pc_exception_jump` pulses. Sequences exception entry through a drain phase with a watchdog.

## Interface
Parameters:
- `ADDR_W`, default `InstAddrBusWidth` (32): width of PC/target buses.
- `DRAIN_MAX`, default 15: maximum EXC_DRAIN cycles before a forced redirect (1..255).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stallreq_id`  in  1  ID stage stall request (operand hazard).
- `stallreq_ex`  in  1  EX stage stall request (multi-cycle mul/div).
- `stallreq_mem`  in  1  MEM stage stall request (load/store not complete).
- `branch_flag`  in  1  EX resolved a taken branch or jump.
- `branch_target`  in  ADDR_W  branch destination.
- `excp_valid`  in  1  MEM stage reports an exception or eret.
- `excp_target`  in  ADDR_W  handler address, or EPC for eret.
- `pause`  out  6  stall vector: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
- `flush_pipe`  out  1  clear IF/ID, ID/EX and EX/MEM registers.
- `flush_front`  out  1  clear IF/ID and ID/EX only (branch).
- `pc_flush`  out  1  branch redirect pulse to `pc_reg`.
- `pc_jump`  out  ADDR_W  branch redirect target.
- `pc_exception_flush`  out  1  exception redirect pulse to `pc_reg`.
- `pc_exception_jump`  out  ADDR_W  exception redirect target.
- `excp_ack`  out  1  one-cycle acknowledge of an accepted `excp_valid`.
- `drain_timeout`  out  1  sticky flag: the watchdog fired at least once.

## Operation
- States: RUN, EXC_DRAIN, EXC_REDIRECT. Reset enters RUN.
- RUN: `pause` is combinational, highest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - none → 0
- EXC_DRAIN: `pause` = 6'b111111.
- EXC_REDIRECT: `pause` = 0.
- Branch acceptance: only in RUN, when `pause[3]`=0, `excp_valid`=0 and `branch_flag`=1.
  - Registers `pc_jump` <= `branch_target`.
  - Next cycle: `pc_flush`=1 and `flush_front`=1 for exactly one cycle.
- Exception acceptance: only in RUN with `excp_valid`=1, regardless of `pause`.
  - Latches `excp_target`.
  - Pulses `excp_ack` next cycle.
  - Cancels any branch accepted in the same cycle; exception wins.
  - Goes to EXC_DRAIN and loads the drain counter with 0.
- EXC_DRAIN:
  - Each cycle: if `stallreq_mem`=0 or counter == DRAIN_MAX-1, go to EXC_REDIRECT; otherwise counter++.
  - A timeout exit sets `drain_timeout`.
  - `branch_flag` and `excp_valid` are ignored.
- EXC_REDIRECT, one cycle:
  - `pc_exception_flush`=1, `flush_pipe`=1, `pc_exception_jump` = latched target.
  - Then return to RUN.
- A branch pulse already registered when the exception is accepted still fires. The exception redirect follows and overrides it, because `pc_reg` gives the exception flush priority.
- Counter width: 8 bits. It saturates at DRAIN_MAX-1 and never wraps.

## Timing
- Reset values:
  - `pause`=0, `flush_pipe`=0, `flush_front`=0.
  - `pc_flush`=0, `pc_exception_flush`=0, `excp_ack`=0, `drain_timeout`=0.
  - `pc_jump`=0, `pc_exception_jump`=0, state=RUN, counter=0.
- `pause` has zero latency from `stallreq_*` (combinational) and never depends on a redirect output.
- Branch: accepted at edge N; `pc_flush` high in cycle N+1 only.
- Exception, accepted at edge N:
  - `excp_ack` high in N+1; EXC_DRAIN from N+1.
  - EXC_REDIRECT at the earliest in N+2, when `stallreq_mem` is low in cycle N+1.
  - EXC_REDIRECT at the latest in N+1+DRAIN_MAX.
- `excp_valid` held high after acknowledge is re-accepted only on return to RUN. The MEM stage must drop it on `excp_ack`.
- Reset asserted mid-sequence (DRAIN/REDIRECT):
  - Immediate return to RUN with all outputs 0.
  - No partial redirect pulse.
- All redirect outputs are registered; no combinational path from inputs to `pc_*flush`.

## Structure
- The shared `defines.v` holds:
  - state encodings `CTRL_RUN`/`CTRL_DRAIN`/`CTRL_REDIR` (2 bits);
  - the pause masks `PAUSE_ID`/`PAUSE_EX`/`PAUSE_MEM`/`PAUSE_ALL`.
- Flops use `gnrl_dfflr` variants, with reset adapted to the active-high `rst`.
- One natural sub-module: `drain_wdog`, the counter plus timeout compare and sticky flag.

## Test plan
- `stallreq_ex`=1 with the others 0 → `pause`=6'b001111 the same cycle. Add `stallreq_mem`=1 → 6'b011111.
- `branch_flag`=1, target 0x0000_1000, no stall → next cycle `pc_flush`=1, `pc_jump`=0x1000, `flush_front`=1. Pulse lasts 1 cycle.
- `branch_flag`=1 while `stallreq_ex`=1 → no `pc_flush` until stall drops, then exactly one pulse.
- `excp_valid`=1 and `branch_flag`=1 in the same cycle, `excp_target`=0xBFC0_0380, `stallreq_mem` low → `excp_ack` at N+1. At N+2: `pc_exception_flush`=1, `pc_exception_jump`=0xBFC0_0380, `flush_pipe`=1. `pc_flush` never asserted.
- Exception with `stallreq_mem` held high, DRAIN_MAX=15 → `pause`=6'b111111 for 15 cycles, redirect at N+16, `drain_timeout`=1 thereafter.
- `rst` pulsed during EXC_DRAIN → all outputs 0 asynchronously. No `pc_exception_flush` after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM encoding, pause masks,
// and the RUN-state stall priority encoder.
package pipe_ctrl_pkg;

  localparam int InstAddrBusWidth = 32;
  localparam int DrainCntW        = 8;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_REDIR = 2'd2
  } ctrl_state_e;

  // pause bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
  localparam logic [5:0] PAUSE_NONE = 6'b000000;
  localparam logic [5:0] PAUSE_ID   = 6'b000111;
  localparam logic [5:0] PAUSE_EX   = 6'b001111;
  localparam logic [5:0] PAUSE_MEM  = 6'b011111;
  localparam logic [5:0] PAUSE_ALL  = 6'b111111;

  function automatic logic [5:0] run_pause(input logic id, input logic ex, input logic mem);
    if (mem)     return PAUSE_MEM;
    else if (ex) return PAUSE_EX;
    else if (id) return PAUSE_ID;
    else         return PAUSE_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_drain.sv
// Exception drain watchdog: saturating cycle counter, exit decision and sticky timeout flag.
// done_o is combinational from the count and stall input; the flag is registered.
module drain_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic active_i,
  input  logic stall_i,
  output logic done_o,
  output logic timeout_o
);

  localparam logic [DrainCntW-1:0] CntLast = DrainCntW'(DRAIN_MAX - 1);

  logic [DrainCntW-1:0] cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic                 at_last;

  always_comb begin
    at_last = (cnt_q == CntLast);
    done_o  = active_i && (!stall_i || at_last);
    to_d    = to_q | (active_i && stall_i && at_last);
    cnt_d   = cnt_q;
    if (start_i)
      cnt_d = '0;
    else if (active_i && stall_i && !at_last)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, branch/exception redirect arbitration and the
// exception drain sequence. Redirect outputs are registered; pause is combinational.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W    = InstAddrBusWidth,
  parameter int DRAIN_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_target,
  output logic [5:0]        pause,
  output logic              flush_pipe,
  output logic              flush_front,
  output logic              pc_flush,
  output logic [ADDR_W-1:0] pc_jump,
  output logic              pc_exception_flush,
  output logic [ADDR_W-1:0] pc_exception_jump,
  output logic              excp_ack,
  output logic              drain_timeout
);

  ctrl_state_e       state_q, state_d;
  logic              br_pulse_q, br_pulse_d;
  logic              exc_pulse_q, exc_pulse_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
  logic [ADDR_W-1:0] exc_tgt_q, exc_tgt_d;
  logic              exc_accept, br_accept, in_drain, drain_done;

  always_comb begin
    pause = PAUSE_NONE;
    unique case (state_q)
      CTRL_RUN:   pause = run_pause(stallreq_id, stallreq_ex, stallreq_mem);
      CTRL_DRAIN: pause = PAUSE_ALL;
      default:    pause = PAUSE_NONE;
    endcase
  end

  // An exception in the same cycle cancels the branch; EX stall blocks branch acceptance.
  always_comb begin
    exc_accept  = (state_q == CTRL_RUN) && excp_valid;
    br_accept   = (state_q == CTRL_RUN) && !pause[3] && !excp_valid && branch_flag;
    in_drain    = (state_q == CTRL_DRAIN);
    br_pulse_d  = br_accept;
    ack_d       = exc_accept;
    exc_pulse_d = drain_done;
    br_tgt_d    = br_accept  ? branch_target : br_tgt_q;
    exc_tgt_d   = exc_accept ? excp_target   : exc_tgt_q;
    state_d     = state_q;
    unique case (state_q)
      CTRL_RUN:   if (exc_accept) state_d = CTRL_DRAIN;
      CTRL_DRAIN: if (drain_done) state_d = CTRL_REDIR;
      default:    state_d = CTRL_RUN;
    endcase
  end

  drain_wdog #(
    .DRAIN_MAX (DRAIN_MAX)
  ) u_drain_wdog (
    .clk       (clk),
    .rst       (rst),
    .start_i   (exc_accept),
    .active_i  (in_drain),
    .stall_i   (stallreq_mem),
    .done_o    (drain_done),
    .timeout_o (drain_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CTRL_RUN;
      br_pulse_q  <= 1'b0;
      exc_pulse_q <= 1'b0;
      ack_q       <= 1'b0;
      br_tgt_q    <= '0;
      exc_tgt_q   <= '0;
    end else begin
      state_q     <= state_d;
      br_pulse_q  <= br_pulse_d;
      exc_pulse_q <= exc_pulse_d;
      ack_q       <= ack_d;
      br_tgt_q    <= br_tgt_d;
      exc_tgt_q   <= exc_tgt_d;
    end
  end

  assign pc_flush           = br_pulse_q;
  assign flush_front        = br_pulse_q;
  assign pc_jump            = br_tgt_q;
  assign pc_exception_flush = exc_pulse_q;
  assign flush_pipe         = exc_pulse_q;
  assign pc_exception_jump  = exc_tgt_q;
  assign excp_ack           = ack_q;

endmodule
